// File: rtl/risc5_muldiv.sv
// Iterative multiply/divide unit shared by the MUL and DIV decode paths of the core.
// Latency: W+1 stall cycles per operation (load + W iterations), result in the following cycle.
// Backpressure: stall = run & ~rst & (S != W+1); the core holds run until stall falls.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 operation requested, held by the core until stall falls
//   op                  0 = multiply, 1 = divide; sampled in the load cycle
//   sgn                 1 = two's complement operands, 0 = unsigned; sampled in the load cycle
//   x, y                multiplicand/dividend and multiplier/divisor; sampled in the load cycle
//   stall               combinational busy indication
//   res_lo, res_hi      mul: low/high product halves; div: quotient/remainder
//
// Build option: define MULDIV_DIV_EN to include the divide datapath. Without it,
// a divide request is refused: stall stays low and the results read zero that cycle.
module risc5_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         op,
    input  logic         sgn,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         stall,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);

    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] S_IDLE = '0;
    localparam logic [CW-1:0] S_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] S_DONE = CW'(W + 1);
    localparam logic [W-1:0]  ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Magnitude of a possibly signed operand. -2^(W-1) maps onto itself,
    // which read as unsigned is exactly its magnitude.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s & v[W-1]) ? -v : v;
    endfunction

    // Step counter and datapath state
    logic [CW-1:0] s_q,  s_d;
    logic [W-1:0]  hi_q, hi_d;   // mul: upper accumulator; div: partial remainder
    logic [W-1:0]  lo_q, lo_d;   // mul: multiplier/low product; div: dividend/quotient
    logic [W-1:0]  m_q,  m_d;    // mul: multiplicand magnitude; div: divisor magnitude
    logic          sx_q, sx_d;
    logic          sy_q, sy_d;

`ifdef MULDIV_DIV_EN
    logic          op_q,   op_d;
    logic          z0_q,   z0_d;
    logic [W-1:0]  xraw_q, xraw_d;
`endif

    logic          load_ok;
    logic [W:0]    mul_sum;
    logic [2*W-1:0] prod;

`ifdef MULDIV_DIV_EN
    logic [W:0]    div_t;
    logic [W:0]    div_diff;
    logic [W-1:0]  q_f;
    logic [W-1:0]  r_f;
    logic [W-1:0]  y_s;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s_d     = s_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
`ifdef MULDIV_DIV_EN
        op_d    = op_q;
        z0_d    = z0_q;
        xraw_d  = xraw_q;
        load_ok = run;
        div_t   = {hi_q, lo_q[W-1]};
        div_diff = div_t - {1'b0, m_q};
`else
        // Divide requests are refused without the divide datapath.
        load_ok = run & ~op;
`endif
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {W{1'b0}})};

        if (s_q == S_IDLE) begin
            // Load cycle; with run low the registers hold the last result.
            if (load_ok) begin
                sx_d = sgn & x[W-1];
                sy_d = sgn & y[W-1];
                hi_d = '0;
                s_d  = S_ONE;
`ifdef MULDIV_DIV_EN
                op_d   = op;
                z0_d   = (y == '0);
                xraw_d = x;
                if (op) begin
                    lo_d = mag(x, sgn);
                    m_d  = mag(y, sgn);
                end else begin
                    lo_d = mag(y, sgn);
                    m_d  = mag(x, sgn);
                end
`else
                lo_d = mag(y, sgn);
                m_d  = mag(x, sgn);
`endif
            end
        end else if (s_q == S_DONE) begin
            // Result consumed this cycle; a held run reloads one cycle later.
            s_d = S_IDLE;
        end else if (!run) begin
            // Abort: partial state is simply abandoned.
            s_d = S_IDLE;
        end else begin
            s_d = s_q + S_ONE;
`ifdef MULDIV_DIV_EN
            if (op_q) begin
                // Restoring division: shift remainder/dividend left, try subtract.
                // The remainder stays below the divisor, so bit W of the
                // difference is set exactly when the subtraction would go negative.
                if (!div_diff[W]) begin
                    hi_d = div_diff[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = div_t[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[W:1];
                lo_d = {mul_sum[0], lo_q[W-1:1]};
            end
`else
            // Radix-2 shift-add: add multiplicand on multiplier LSB, shift right.
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= S_IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            sx_q   <= 1'b0;
            sy_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_q   <= 1'b0;
            z0_q   <= 1'b0;
            xraw_q <= '0;
`endif
        end else begin
            s_q    <= s_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
`ifdef MULDIV_DIV_EN
            op_q   <= op_d;
            z0_q   <= z0_d;
            xraw_q <= xraw_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result sign fix-up and stall
    // ------------------------------------------------------------------
    always_comb begin
        prod = (sx_q ^ sy_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
`ifdef MULDIV_DIV_EN
        // Floored division from magnitudes: the quotient is negated when
        // signs differ, the remainder takes the dividend's sign, and a
        // nonzero remainder with differing signs moves one step toward -inf.
        y_s = sy_q ? -m_q : m_q;
        q_f = (sx_q ^ sy_q) ? -lo_q : lo_q;
        r_f = sx_q ? -hi_q : hi_q;
        if ((sx_q ^ sy_q) && (hi_q != '0)) begin
            q_f = q_f - ONE_W;
            r_f = r_f + y_s;
        end
        if (z0_q) begin
            q_f = '1;
            r_f = xraw_q;
        end
        if (op_q) begin
            res_lo = q_f;
            res_hi = r_f;
        end else begin
            res_lo = prod[W-1:0];
            res_hi = prod[2*W-1:W];
        end
        stall = run & ~rst & (s_q != S_DONE);
`else
        res_lo = prod[W-1:0];
        res_hi = prod[2*W-1:W];
        if ((s_q == S_IDLE) && run && op) begin
            res_lo = '0;
            res_hi = '0;
        end
        stall = run & ~rst & (s_q != S_DONE) & ~((s_q == S_IDLE) & op);
`endif
    end

endmodule

// File: tb/tb_risc5_muldiv.sv
// Directed bench for risc5_muldiv with W=32: multiply/divide results, latency,
// back-to-back operation, abort, reset mid-operation and the divide-less build.
module tb_risc5_muldiv;

    logic        clk;
    logic        rst;
    logic        run;
    logic        op;
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] res_lo;
    logic [31:0] res_hi;

    int checks;
    int failures;

    risc5_muldiv #(.W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .op     (op),
        .sgn    (sgn),
        .x      (x),
        .y      (y),
        .stall  (stall),
        .res_lo (res_lo),
        .res_hi (res_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a new request at the current (negedge) time.
    task automatic start(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
        op  = o;
        sgn = s;
        x   = a;
        y   = b;
        run = 1'b1;
    endtask

    // Count stall-high cycles until completion, then check latency and results.
    // Leaves time in the done cycle (stall low), away from the clock edge.
    task automatic wait_done(input string tag, input logic [31:0] elo, input logic [31:0] ehi);
        int cnt;
        cnt = 0;
        #1;
        while (stall && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check({tag, "_lat"}, 64'(cnt), 64'd33);
        check({tag, "_lo"}, {32'd0, res_lo}, {32'd0, elo});
        check({tag, "_hi"}, {32'd0, res_hi}, {32'd0, ehi});
    endtask

    task automatic one_op(input string tag, input logic o, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
        start(o, s, a, b);
        wait_done(tag, elo, ehi);
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        run = 1'b0;
        op  = 1'b0;
        sgn = 1'b0;
        x   = '0;
        y   = '0;
        #1;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_res", {res_hi, res_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", {63'd0, stall}, 64'd0);

        // Multiply
        one_op("mul_s_m3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF);
        #1;
        check("hold_res", {res_hi, res_lo}, 64'hFFFFFFFF_FFFFFFEB);
        check("hold_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        one_op("mul_u_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
        one_op("mul_s_min", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);
        one_op("mul_u_2p32", 1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001);
        one_op("mul_s_m1m1", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);

        // Back-to-back with run held high
        start(1'b0, 1'b0, 32'd3, 32'd5);
        wait_done("b2b_a", 32'h0000000F, 32'h00000000);
        x = 32'd6;
        y = 32'd7;
        @(negedge clk);
        #1;
        check("b2b_reload_stall", {63'd0, stall}, 64'd1);
        #1;
        wait_done("b2b_b", 32'h0000002A, 32'h00000000);
        run = 1'b0;
        @(negedge clk);

        // Abort at S=10, then a fresh operation
        start(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        #1;
        check("abort_busy", {63'd0, stall}, 64'd1);
        run = 1'b0;
        @(negedge clk);
        one_op("after_abort", 1'b0, 1'b0, 32'd6, 32'd7, 32'h0000002A, 32'h00000000);

`ifdef MULDIV_DIV_EN
        one_op("div_s_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFC, 32'h00000001);
        one_op("div_s_7_m2", 1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFFF);
        one_op("div_u_big", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001);
        one_op("div_s_100_7", 1'b1, 1'b1, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
        one_op("div_s_m8_m3", 1'b1, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE);
        one_op("div_s_m6_3", 1'b1, 1'b1, 32'hFFFFFFFA, 32'h00000003, 32'hFFFFFFFE, 32'h00000000);
        one_op("div0_u", 1'b1, 1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678);
        one_op("div0_s", 1'b1, 1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678);
`else
        // Divide refused: stall never rises and results read zero while requested.
        one_op("pre_nodiv", 1'b0, 1'b0, 32'd6, 32'd7, 32'h0000002A, 32'h00000000);
        start(1'b1, 1'b0, 32'd100, 32'd7);
        #1;
        check("nodiv_stall0", {63'd0, stall}, 64'd0);
        check("nodiv_res0", {res_hi, res_lo}, 64'd0);
        @(negedge clk);
        #1;
        check("nodiv_stall1", {63'd0, stall}, 64'd0);
        check("nodiv_res1", {res_hi, res_lo}, 64'd0);
        run = 1'b0;
        @(negedge clk);
        one_op("post_nodiv", 1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF);
`endif

        // Reset in the middle of an operation
        one_op("pre_rst", 1'b0, 1'b0, 32'd6, 32'd7, 32'h0000002A, 32'h00000000);
        start(1'b0, 1'b0, 32'd11, 32'd13);
        repeat (17) @(negedge clk);
        #1;
        check("mid_busy", {63'd0, stall}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", {63'd0, stall}, 64'd0);
        check("mid_rst_res", {res_hi, res_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        one_op("after_rst", 1'b0, 1'b0, 32'd11, 32'd13, 32'h0000008F, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
